// File: rtl/csr_perf_counters.sv
// Performance counters (cycle, time, instret, hpm) with CSR read and machine-mode write ports.
// Latency: reads are combinational from registered counters; writes land on the next edge, ack one cycle later.
// Backpressure: none; every read and write completes in a single cycle.
module csr_perf_counters #(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_HPM       = 4,
    parameter int RETIRE_WIDTH  = 1,
    parameter int TIME_DIV      = 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]     retire_count_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    input  logic [11:0]                           csr_rd_addr_i,
    output logic [31:0]                           csr_rd_data_o,
    output logic                                  csr_rd_valid_o,
    input  logic                                  csr_wr_en_i,
    input  logic [11:0]                           csr_wr_addr_i,
    input  logic [31:0]                           csr_wr_data_i,
    output logic                                  csr_wr_ack_o
);
    localparam int CW = COUNTER_WIDTH;
    localparam int HW = COUNTER_WIDTH - 32;
    // Slot index equals the CSR address offset: 0 cycle, 1 time, 2 instret, 3.. hpm
    localparam int NC = 3 + NUM_HPM;
    localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic [CW-1:0] cnt_q [NC];
    logic [CW-1:0] cnt_d [NC];
    logic [31:0]   inh_q;
    logic [PW-1:0] presc_q;
    logic          ack_q;

    logic [4:0] wr_idx;
    logic       wr_lo;
    logic       wr_hi;
    logic       wr_inh;
    logic       wr_cnt_hit;
    logic       presc_wrap;

    assign wr_idx     = csr_wr_addr_i[4:0];
    assign wr_lo      = csr_wr_en_i && (csr_wr_addr_i[11:5] == 7'b1011000);
    assign wr_hi      = csr_wr_en_i && (csr_wr_addr_i[11:5] == 7'b1011100);
    assign wr_inh     = csr_wr_en_i && (csr_wr_addr_i == 12'h320);
    assign wr_cnt_hit = (wr_lo || wr_hi) && (wr_idx != 5'd1) && (int'(wr_idx) < NC);
    assign presc_wrap = (presc_q == PW'(TIME_DIV - 1));

    // A write replaces the registered value and drops that cycle's increment
    always_comb begin
        for (int k = 0; k < NC; k++) begin
            cnt_d[k] = cnt_q[k];
            if (k == 1) begin
                cnt_d[k] = cnt_q[k] + CW'(presc_wrap);
            end else if (!inh_q[k]) begin
                if (k == 0)
                    cnt_d[k] = cnt_q[k] + CW'(1);
                else if (k == 2)
                    cnt_d[k] = cnt_q[k] + CW'(retire_count_i);
                else
                    cnt_d[k] = cnt_q[k] + CW'(hpm_event_i[(k >= 3) ? k - 3 : 0]);
            end
            if (k != 1 && int'(wr_idx) == k) begin
                if (wr_lo)
                    cnt_d[k] = {cnt_q[k][CW-1:32], csr_wr_data_i};
                if (wr_hi)
                    cnt_d[k] = {csr_wr_data_i[HW-1:0], cnt_q[k][31:0]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < NC; k++)
                cnt_q[k] <= '0;
            inh_q   <= '0;
            presc_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NC; k++)
                cnt_q[k] <= cnt_d[k];
            presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            if (wr_inh)
                inh_q <= csr_wr_data_i & INH_MASK;
            ack_q <= wr_cnt_hit || wr_inh;
        end
    end

    assign csr_wr_ack_o = ack_q;

    logic [4:0]    rd_idx;
    logic [CW-1:0] sel;
    logic          sel_ok;
    logic [31:0]   hi_ext;
    logic          m_ok;

    assign rd_idx = csr_rd_addr_i[4:0];

    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (int'(rd_idx) == k) begin
                sel    = cnt_q[k];
                sel_ok = 1'b1;
            end
        end
        hi_ext         = '0;
        hi_ext[HW-1:0] = sel[CW-1:32];
        m_ok           = sel_ok && (rd_idx != 5'd1);

        csr_rd_data_o  = '0;
        csr_rd_valid_o = 1'b0;
        case (csr_rd_addr_i[11:5])
            7'b1100000: begin
                csr_rd_valid_o = sel_ok;
                csr_rd_data_o  = sel[31:0];
            end
            7'b1100100: begin
                csr_rd_valid_o = sel_ok;
                csr_rd_data_o  = hi_ext;
            end
            7'b1011000: begin
                csr_rd_valid_o = m_ok;
                csr_rd_data_o  = m_ok ? sel[31:0] : '0;
            end
            7'b1011100: begin
                csr_rd_valid_o = m_ok;
                csr_rd_data_o  = m_ok ? hi_ext : '0;
            end
            default: begin
                if (csr_rd_addr_i == 12'h320) begin
                    csr_rd_valid_o = 1'b1;
                    csr_rd_data_o  = inh_q;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_csr_perf_counters.sv
// Bench for csr_perf_counters: directed scenarios plus random traffic against a reference model.
module tb_csr_perf_counters;
    localparam int CW   = 64;
    localparam int NHPM = 4;
    localparam int RW   = 2;
    localparam int TDIV = 4;
    localparam int NC   = 3 + NHPM;
    localparam logic [31:0] INH_MASK = 32'h7D;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  retire;
    logic [3:0]  ev;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        ack;

    csr_perf_counters #(
        .COUNTER_WIDTH(CW), .NUM_HPM(NHPM), .RETIRE_WIDTH(RW), .TIME_DIV(TDIV)
    ) dut (
        .clk_i(clk), .reset_i(rst), .retire_count_i(retire), .hpm_event_i(ev),
        .csr_rd_addr_i(rd_addr), .csr_rd_data_o(rd_data), .csr_rd_valid_o(rd_valid),
        .csr_wr_en_i(wr_en), .csr_wr_addr_i(wr_addr), .csr_wr_data_i(wr_data),
        .csr_wr_ack_o(ack)
    );

    int total = 0;
    int bad   = 0;

    // Model: counters by CSR offset; time derived from cycles elapsed since reset
    logic [63:0]     m_cnt [NC];
    logic [31:0]     m_inh;
    longint unsigned m_ticks;
    logic            m_ack;
    bit              chk_en = 1'b0;

    logic [11:0] addr_tab [16] = '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC06, 12'hC07,
                                   12'hC80, 12'hC81, 12'hC86, 12'hB00, 12'hB01, 12'hB02,
                                   12'hB05, 12'hB80, 12'hB81, 12'hB86};

    always @(posedge clk) assert (retire <= 2'(RW));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h rd_addr=%h t=%0t", name, act, exp, rd_addr, $time);
        end
    endtask

    function automatic int slot(input logic [11:0] a, input int base);
        int k;
        k = int'(a) - base;
        return (k >= 0 && k < NC) ? k : -1;
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic v, output logic [31:0] d);
        int k;
        v = 1'b0;
        d = '0;
        if (a == 12'h320) begin
            v = 1'b1; d = m_inh;
        end else if (slot(a, 'hC00) >= 0) begin
            k = slot(a, 'hC00); v = 1'b1; d = m_cnt[k][31:0];
        end else if (slot(a, 'hC80) >= 0) begin
            k = slot(a, 'hC80); v = 1'b1; d = m_cnt[k][63:32];
        end else if (slot(a, 'hB00) >= 0 && slot(a, 'hB00) != 1) begin
            k = slot(a, 'hB00); v = 1'b1; d = m_cnt[k][31:0];
        end else if (slot(a, 'hB80) >= 0 && slot(a, 'hB80) != 1) begin
            k = slot(a, 'hB80); v = 1'b1; d = m_cnt[k][63:32];
        end
    endfunction

    task automatic model_step();
        logic [63:0] old [NC];
        int lo;
        int hi;
        if (rst) begin
            for (int k = 0; k < NC; k++) m_cnt[k] = '0;
            m_inh = '0; m_ticks = 0; m_ack = 1'b0;
            return;
        end
        old = m_cnt;
        m_ticks++;
        m_cnt[1] = m_ticks / TDIV;
        if (!m_inh[0]) m_cnt[0] = old[0] + 64'd1;
        if (!m_inh[2]) m_cnt[2] = old[2] + 64'(retire);
        for (int i = 0; i < NHPM; i++)
            if (!m_inh[3+i]) m_cnt[3+i] = old[3+i] + 64'(ev[i]);
        m_ack = 1'b0;
        if (wr_en) begin
            lo = slot(wr_addr, 'hB00);
            hi = slot(wr_addr, 'hB80);
            if (lo >= 0 && lo != 1) begin m_cnt[lo] = {old[lo][63:32], wr_data}; m_ack = 1'b1; end
            if (hi >= 0 && hi != 1) begin m_cnt[hi] = {wr_data, old[hi][31:0]}; m_ack = 1'b1; end
            if (wr_addr == 12'h320) begin m_inh = wr_data & INH_MASK; m_ack = 1'b1; end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic lit(input string name, input logic [11:0] a, input logic [31:0] exp_d, input logic exp_v);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp_d);
        chk({name, "_valid"}, {31'b0, rd_valid}, {31'b0, exp_v});
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return addr_tab[r];
        if (r == 16) return 12'h320;
        if (r == 17) return 12'hB83;
        if (r == 18) return 12'hB84;
        return 12'($urandom);
    endfunction

    always @(negedge clk) begin : cmp_proc
        logic        v;
        logic [31:0] d;
        if (chk_en) begin
            model_read(rd_addr, v, d);
            chk("cmp_rd_valid", {31'b0, rd_valid}, {31'b0, v});
            chk("cmp_rd_data", rd_data, d);
            chk("cmp_ack", {31'b0, ack}, {31'b0, m_ack});
        end
    end

    initial begin
        rst = 1'b1; retire = '0; ev = '0; rd_addr = 12'hC00;
        wr_en = 1'b1; wr_addr = 12'hB00; wr_data = 32'd50;
        cyc(); cyc();
        rst = 1'b0; wr_en = 1'b0;
        chk_en = 1'b1;
        chk("reset_ack", {31'b0, ack}, 32'd0);
        lit("reset_cycle", 12'hC00, 32'd0, 1'b1);
        lit("reset_inh", 12'h320, 32'd0, 1'b1);

        repeat (13) cyc();
        lit("idle_cycle", 12'hC00, 32'd13, 1'b1);
        lit("idle_time", 12'hC01, 32'd3, 1'b1);
        lit("idle_instret", 12'hC02, 32'd0, 1'b1);
        lit("idle_cycleh", 12'hC80, 32'd0, 1'b1);
        lit("unmapped", 12'hC1F, 32'd0, 1'b0);
        lit("mtime_absent", 12'hB01, 32'd0, 1'b0);

        wr(12'hB80, 32'hFFFFFFFF);
        chk("wrap_ack_hi", {31'b0, ack}, 32'd1);
        wr(12'hB00, 32'hFFFFFFFE);
        chk("wrap_ack_lo", {31'b0, ack}, 32'd1);
        lit("wrap_lo0", 12'hC00, 32'hFFFFFFFE, 1'b1);
        lit("wrap_hi0", 12'hC80, 32'hFFFFFFFF, 1'b1);
        cyc(); cyc();
        lit("wrap_lo2", 12'hC00, 32'd0, 1'b1);
        lit("wrap_hi2", 12'hC80, 32'd0, 1'b1);

        wr(12'hB80, 32'd0);
        wr(12'hB00, 32'hFFFFFFFF);
        lit("carry_pre_hi", 12'hC80, 32'd0, 1'b1);
        cyc();
        lit("carry_hi", 12'hC80, 32'd1, 1'b1);
        lit("carry_lo", 12'hC00, 32'd0, 1'b1);

        retire = 2'd2; cyc();
        retire = 2'd1; cyc();
        retire = 2'd0; cyc();
        retire = 2'd2; cyc();
        retire = 2'd0;
        lit("retire_sum", 12'hC02, 32'd5, 1'b1);
        retire = 2'd2;
        wr(12'hB02, 32'd100);
        retire = 2'd0;
        lit("retire_wr_wins", 12'hC02, 32'd100, 1'b1);
        lit("retire_malias", 12'hB02, 32'd100, 1'b1);

        wr(12'hB80, 32'd0);
        wr(12'hB00, 32'd1000);
        wr(12'h320, 32'hFFFF_FFFF & 32'h5);
        lit("inh_read", 12'h320, 32'h5, 1'b1);
        for (int n = 0; n < 20; n++) begin
            retire = 2'($urandom_range(0, 2));
            cyc();
        end
        retire = 2'd0;
        lit("inh_cycle", 12'hC00, 32'd1001, 1'b1);
        lit("inh_instret", 12'hC02, 32'd100, 1'b1);
        wr(12'h320, 32'd0);
        lit("uninh_same", 12'hC00, 32'd1001, 1'b1);
        cyc();
        lit("uninh_next", 12'hC00, 32'd1002, 1'b1);

        ev = 4'b0100;
        repeat (7) cyc();
        ev = 4'b0000;
        lit("hpm5", 12'hC05, 32'd7, 1'b1);
        lit("hpm3", 12'hC03, 32'd0, 1'b1);
        lit("hpm4", 12'hC04, 32'd0, 1'b1);
        lit("hpm6", 12'hC06, 32'd0, 1'b1);
        lit("hpm_absent", 12'hC07, 32'd0, 1'b0);
        wr(12'hC05, 32'd9);
        chk("user_wr_noack", {31'b0, ack}, 32'd0);
        lit("user_wr_ignored", 12'hC05, 32'd7, 1'b1);
        wr(12'hB05, 32'd9);
        chk("mach_wr_ack", {31'b0, ack}, 32'd1);
        lit("mach_wr_val", 12'hC05, 32'd9, 1'b1);

        for (int n = 0; n < 800; n++) begin
            retire  = 2'($urandom_range(0, 2));
            ev      = 4'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = pick_addr();
            wr_data = $urandom;
            if ($urandom_range(0, 3) == 0) wr_data = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            if (wr_addr == 12'h320 && $urandom_range(0, 1) == 0) wr_data = 32'd0;
            rd_addr = pick_addr();
            cyc();
        end
        rst = 1'b0; wr_en = 1'b0;

        rst = 1'b1;
        wr(12'hB00, 32'd50);
        rst = 1'b0;
        chk("rst_wr_noack", {31'b0, ack}, 32'd0);
        lit("rst_wr_cycle", 12'hC00, 32'd0, 1'b1);
        lit("rst_wr_time", 12'hC01, 32'd0, 1'b1);
        lit("rst_wr_hpm", 12'hB05, 32'd0, 1'b1);
        cyc();
        lit("post_rst_cycle", 12'hC00, 32'd1, 1'b1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_perf_counters.md
Name: csr_perf_counters

Overview:
- Parametrised performance-counter unit for the CSR path: cycle, time, instret, plus NUM_HPM hardware event counters, all COUNTER_WIDTH bits wide.
- Provides combinational CSR reads of the user low/high aliases (0xC00/0xC80 range) and the machine aliases (0xB00/0xB80 range).
- Accepts machine-mode writes from the WB-stage CSR write port.
- Supports multi-instruction retirement per cycle and a per-counter inhibit register (mcountinhibit, 0x320).

Parameters:
COUNTER_WIDTH  64  counter width, legal 33..64; high alias returns bits [COUNTER_WIDTH-1:32], zero-extended
NUM_HPM  4  number of hpmcounters (hpmcounter3..hpmcounter(3+NUM_HPM-1)), legal 0..29
RETIRE_WIDTH  1  max instructions retired per cycle, legal 1..4
TIME_DIV  1  clk_i cycles per time increment, legal >=1

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
retire_count_i  in  $clog2(RETIRE_WIDTH+1)  instructions retired this cycle (0..RETIRE_WIDTH)
hpm_event_i  in  max(NUM_HPM,1)  one pulse per counter per cycle, bit i feeds hpmcounter(3+i)
csr_rd_addr_i  in  12  CSR read address (ID stage)
csr_rd_data_o  out  32  read data, combinational
csr_rd_valid_o  out  1  address maps to an implemented counter CSR, combinational
csr_wr_en_i  in  1  write strobe (WB stage, valid instr only)
csr_wr_addr_i  in  12  write address
csr_wr_data_i  in  32  write data
csr_wr_ack_o  out  1  registered; pulses 1 cycle after a write that hit a writable CSR

Behaviour:
- Interface: one clock clk_i; reset_i is synchronous and active-high.
- Reset: all counters, time prescaler and mcountinhibit cleared to 0; csr_wr_ack_o=0. csr_rd_data_o and csr_rd_valid_o are combinational; after reset, reads of any counter return 0.
- Read map:
  - 0xC00/0xB00 cycle low; 0xC80/0xB80 cycle high.
  - 0xC01/0xC81 time low/high.
  - 0xC02/0xB02 instret low; 0xC82/0xB82 instret high.
  - 0xC03+i/0xB03+i hpm i low; 0xC83+i/0xB83+i hpm i high, for i<NUM_HPM.
  - 0x320 mcountinhibit: bit0 cycle, bit2 instret, bit(3+i) hpm i; all other bits read 0.
  - Unmapped address: data 0, valid 0.
- Read timing: reads return the registered value, i.e. the value before this cycle's update. There is no write-to-read forwarding; the pipeline handles that hazard.
- Increment, per cycle, when not inhibited:
  - cycle += 1.
  - instret += retire_count_i.
  - hpm i += hpm_event_i[i].
  - All arithmetic wraps modulo 2^COUNTER_WIDTH; all-ones + 1 = 0 with no flag.
  - retire_count_i > RETIRE_WIDTH is illegal; the bench asserts against it.
- Time:
  - Prescaler counts 0..TIME_DIV-1. time += 1 in the cycle the prescaler wraps to 0.
  - TIME_DIV=1 means time increments every cycle.
  - time is never inhibited and is read-only.
- Writes, effective at the next clk_i edge:
  - Writable: machine aliases 0xB00/0xB02/0xB03+i (low) and 0xB80/0xB82/0xB83+i (high), plus 0x320.
  - A low write replaces bits [31:0] and keeps the high bits. A high write replaces bits [COUNTER_WIDTH-1:32] with csr_wr_data_i truncated to that width, and keeps the low bits.
  - A write to a counter takes precedence over that counter's increment in the same cycle: the written value is stored and that cycle's increment is dropped.
  - Writes to user aliases, time, or unmapped addresses are ignored, with csr_wr_ack_o=0.
  - A 0x320 write stores only the implemented bits. A new inhibit setting first affects the increment of the cycle after the write.
- Low-half carry: a low write never generates a carry. An increment that carries out of bit 31 propagates into the high half in the same cycle.
- Reset mid-operation: reset_i dominates writes and increments. A write strobed in the reset cycle is lost and is not acked.
- NUM_HPM=0: no hpm counters exist; hpm_event_i is ignored and hpm addresses read invalid.

Test Plan:
- Reset, then run 10 idle cycles with TIME_DIV=1 -> read 0xC00=10, 0xC01=10, 0xC02=0, 0xC80=0, valid=1; read 0xC1F -> data 0, valid 0.
- Wrap and carry:
  - Write 0xB00=0xFFFFFFFE and 0xB80=0xFFFFFFFF (COUNTER_WIDTH=64).
  - 0xC00 reads 0xFFFFFFFE, 0xC80 reads 0xFFFFFFFF; two cycles later both halves read 0x00000000.
  - Separately, with high=0 and low=0xFFFFFFFF, one cycle later 0xC80 reads 1.
- RETIRE_WIDTH=2: drive retire_count_i sequence 2,1,0,2 -> 0xC02 reads 5. A same-cycle write 0xB02=100 with retire_count_i=2 -> 100, not 102.
- Inhibit: write 0x320=0x5, hold 20 cycles -> cycle and instret frozen, time still advancing. Write 0x320=0 -> cycle resumes +1 per cycle starting the cycle after the write.
- hpm: NUM_HPM=4, pulse hpm_event_i[2] 7 times -> 0xC05=7, others 0. Write 0xC05=9 -> ignored, ack 0; write 0xB05=9 -> ack 1 next cycle, read 9.
- TIME_DIV=4: after reset, 13 cycles -> time=3. Assert reset_i with a simultaneous write 0xB00=50 -> all counters 0, no ack.
